// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, req/ready memory port, valid/ready hand-off to ID, stall on B-type/JALR.
// Optional direct-mapped I-cache enabled with `define IF_ICACHE_EN.
module if_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned ICACHE_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    input  logic        branch_en,
    input  logic [31:0] branch_dest
);

    typedef enum logic [1:0] {FETCH, ISSUE, BR_WAIT} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        req_n;
    logic [31:0] addr_n;
    logic        valid_n;
    logic [31:0] inst_n, pcout_n;
    logic        discard, discard_n;
    logic        hit;
    logic [31:0] hit_data;
    logic        is_branch;
    logic [31:0] dest;

    if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_lines_check
        $error("ICACHE_LINES must be a power of 2 and at least 2");
    end

`ifdef IF_ICACHE_EN
    localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;
    // With a cache, FETCH is entered idle so the lookup for the new PC happens first.
    localparam logic REQ_ON_ENTRY = 1'b0;

    logic [ICACHE_LINES-1:0] line_valid;
    logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
    logic [31:0]             line_data [ICACHE_LINES];
    logic [IDX_W-1:0]        rd_idx, wr_idx;
    logic                    fill_en;

    assign rd_idx   = pc[2 +: IDX_W];
    assign wr_idx   = mem_addr[2 +: IDX_W];
    assign hit      = line_valid[rd_idx] && (line_tag[rd_idx] == pc[31:2+IDX_W]);
    assign hit_data = line_data[rd_idx];
    assign fill_en  = rdy && (state == FETCH) && mem_req && mem_ready && !discard;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid <= '0;
        end else if (fill_en) begin
            line_valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            line_tag[wr_idx]  <= mem_addr[31:2+IDX_W];
            line_data[wr_idx] <= mem_data;
        end
    end
`else
    localparam logic REQ_ON_ENTRY = 1'b1;

    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    assign is_branch = (inst_out[6:0] == 7'b1100011) || (inst_out[6:0] == 7'b1100111);
    assign dest      = branch_dest & ~32'h3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            id_valid <= 1'b0;
            inst_out <= '0;
            pc_out   <= '0;
            discard  <= 1'b0;
        end else if (rdy) begin
            state    <= state_n;
            pc       <= pc_n;
            mem_req  <= req_n;
            mem_addr <= addr_n;
            id_valid <= valid_n;
            inst_out <= inst_n;
            pc_out   <= pcout_n;
            discard  <= discard_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        req_n     = mem_req;
        addr_n    = mem_addr;
        valid_n   = id_valid;
        inst_n    = inst_out;
        pcout_n   = pc_out;
        discard_n = discard;

        unique case (state)
            FETCH: begin
                if (mem_req) begin
                    if (mem_ready) begin
                        if (discard) begin
                            // stale response dropped; keep the port busy with the redirected PC
                            discard_n = 1'b0;
                            addr_n    = pc;
                        end else begin
                            inst_n  = mem_data;
                            pcout_n = pc;
                            valid_n = 1'b1;
                            req_n   = 1'b0;
                            state_n = ISSUE;
                        end
                    end
                end else if (hit) begin
                    inst_n  = hit_data;
                    pcout_n = pc;
                    valid_n = 1'b1;
                    state_n = ISSUE;
                end else begin
                    req_n  = 1'b1;
                    addr_n = pc;
                end
            end
            ISSUE: begin
                if (id_ready) begin
                    valid_n = 1'b0;
                    if (is_branch) begin
                        state_n = BR_WAIT;
                    end else begin
                        pc_n    = pc + 32'd4;
                        state_n = FETCH;
                        req_n   = REQ_ON_ENTRY;
                        addr_n  = REQ_ON_ENTRY ? (pc + 32'd4) : mem_addr;
                    end
                end
            end
            BR_WAIT: begin
            end
            default: state_n = FETCH;
        endcase

        // A redirect overrides whatever the state machine decided above.
        if (branch_en) begin
            pc_n    = dest;
            valid_n = 1'b0;
            state_n = FETCH;
            if ((state == FETCH) && mem_req && !mem_ready) begin
                discard_n = 1'b1;
                req_n     = mem_req;
                addr_n    = mem_addr;
            end else begin
                discard_n = 1'b0;
                req_n     = REQ_ON_ENTRY;
                addr_n    = REQ_ON_ENTRY ? dest : mem_addr;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, sequential fetch, branch stall, redirect/discard, backpressure, rdy, wrap.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        branch_en;
    logic [31:0] branch_dest;

    int checks;
    int failures;

`ifdef IF_ICACHE_EN
    localparam int  ENTRY_GAP = 1;
    localparam bit  PASS2_MEM = 1'b0;
`else
    localparam int  ENTRY_GAP = 0;
    localparam bit  PASS2_MEM = 1'b1;
`endif

    localparam logic [31:0] ADDI  = 32'h0010_0093;
    localparam logic [31:0] ADDI2 = 32'h0050_0113;
    localparam logic [31:0] BEQ   = 32'h0020_8463;

    if_fetch #(
        .RESET_PC    (32'h0000_0000),
        .ICACHE_LINES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .inst_out   (inst_out),
        .pc_out     (pc_out),
        .branch_en  (branch_en),
        .branch_dest(branch_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One fetch/issue through to the ID handshake; id_ready must already be 1.
    task automatic fetch_one(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input bit exp_mem, input int exp_gap);
        int n;
        n = 0;
        while (!mem_req && !id_valid && n < 4) begin
            tick();
            n++;
        end
        chk({tag, "_gap"}, n, exp_gap);
        chk({tag, "_req"}, {31'b0, mem_req}, {31'b0, exp_mem});
        if (mem_req) begin
            chk({tag, "_addr"}, mem_addr, a);
            mem_ready = 1'b1;
            mem_data  = d;
            tick();
            mem_ready = 1'b0;
        end
        chk({tag, "_valid"}, {31'b0, id_valid}, 32'd1);
        chk({tag, "_pc"}, pc_out, a);
        chk({tag, "_inst"}, inst_out, d);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        rdy         = 1'b1;
        mem_ready   = 1'b0;
        mem_data    = '0;
        id_ready    = 1'b0;
        branch_en   = 1'b0;
        branch_dest = '0;

        // T1 reset
        tick();
        tick();
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_inst", inst_out, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        rst = 1'b0;
        tick();
        chk("t1_req", {31'b0, mem_req}, 32'd1);
        chk("t1_addr", mem_addr, 32'h0);

        // T2 sequential fetch, memory answers after 2 cycles
        tick();
        tick();
        chk("t2_req_held", {31'b0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        mem_data  = ADDI;
        id_ready  = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("t2_valid", {31'b0, id_valid}, 32'd1);
        chk("t2_inst", inst_out, ADDI);
        chk("t2_pc", pc_out, 32'h0);
        chk("t2_req_low", {31'b0, mem_req}, 32'd0);
        tick();
        chk("t2_valid_clr", {31'b0, id_valid}, 32'd0);
        chk("t2_next_req", {31'b0, mem_req}, 32'd1);
        chk("t2_next_addr", mem_addr, 32'h4);

        // T3 branch stall
        mem_ready = 1'b1;
        mem_data  = BEQ;
        tick();
        mem_ready = 1'b0;
        chk("t3_pc", pc_out, 32'h4);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stall_req", {31'b0, mem_req}, 32'd0);
            chk("t3_stall_valid", {31'b0, id_valid}, 32'd0);
        end
        branch_en   = 1'b1;
        branch_dest = 32'h40;
        tick();
        branch_en = 1'b0;
        chk("t3_redir_req", {31'b0, mem_req}, 32'd1);
        chk("t3_redir_addr", mem_addr, 32'h40);

        // JALR at 0x40 also stalls; redirect to 8
        mem_ready = 1'b1;
        mem_data  = 32'h0000_8067;
        tick();
        mem_ready = 1'b0;
        chk("jalr_pc", pc_out, 32'h40);
        tick();
        tick();
        chk("jalr_stall", {31'b0, mem_req}, 32'd0);
        branch_en   = 1'b1;
        branch_dest = 32'h8;
        tick();
        branch_en = 1'b0;
        chk("t4_req8", mem_addr, 32'h8);

        // T4 redirect with outstanding request; low dest bits are dropped
        tick();
        branch_en   = 1'b1;
        branch_dest = 32'h103;
        tick();
        branch_en = 1'b0;
        chk("t4_held_req", {31'b0, mem_req}, 32'd1);
        chk("t4_held_addr", mem_addr, 32'h8);
        mem_ready = 1'b1;
        mem_data  = 32'hDEAD_BEEF;
        id_ready  = 1'b0;
        tick();
        mem_ready = 1'b0;
        chk("t4_dropped", {31'b0, id_valid}, 32'd0);
        chk("t4_rereq", {31'b0, mem_req}, 32'd1);
        chk("t4_new_addr", mem_addr, 32'h100);
        tick();
        chk("t4_still_none", {31'b0, id_valid}, 32'd0);

        // T5 backpressure, then rdy=0 freezes the handshake and ignores branch_en
        mem_ready = 1'b1;
        mem_data  = ADDI2;
        tick();
        mem_ready = 1'b0;
        chk("t5_pc", pc_out, 32'h100);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_bp_valid", {31'b0, id_valid}, 32'd1);
            chk("t5_bp_inst", inst_out, ADDI2);
            chk("t5_bp_pc", pc_out, 32'h100);
        end
        rdy      = 1'b0;
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            branch_en   = (i == 1);
            branch_dest = 32'h200;
            tick();
            chk("t5_rdy_valid", {31'b0, id_valid}, 32'd1);
            chk("t5_rdy_req", {31'b0, mem_req}, 32'd0);
        end
        branch_en = 1'b0;
        rdy       = 1'b1;
        tick();
        chk("t5_hs_valid", {31'b0, id_valid}, 32'd0);
        chk("t5_hs_addr", mem_addr, 32'h104);

        // PC wrap at the top of the address space
        mem_ready = 1'b1;
        mem_data  = BEQ;
        tick();
        mem_ready = 1'b0;
        tick();
        branch_en   = 1'b1;
        branch_dest = 32'hFFFF_FFFC;
        tick();
        branch_en = 1'b0;
        chk("wrap_addr_top", mem_addr, 32'hFFFF_FFFC);
        mem_ready = 1'b1;
        mem_data  = ADDI;
        tick();
        mem_ready = 1'b0;
        chk("wrap_pc_top", pc_out, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr_zero", mem_addr, 32'h0);

        // Reset mid-request; a late mem_ready right after reset is ignored
        rst = 1'b1;
        tick();
        chk("midrst_req", {31'b0, mem_req}, 32'd0);
        rst       = 1'b0;
        mem_ready = 1'b1;
        mem_data  = 32'hBADB_AD00;
        tick();
        mem_ready = 1'b0;
        chk("midrst_late", {31'b0, id_valid}, 32'd0);
        chk("midrst_req2", {31'b0, mem_req}, 32'd1);
        chk("midrst_addr", mem_addr, 32'h0);
        tick();
        chk("midrst_none", {31'b0, id_valid}, 32'd0);

        // T6 four-instruction loop, two passes
        fetch_one("t6a0", 32'h0, ADDI, 1'b1, 0);
        fetch_one("t6a1", 32'h4, ADDI2, 1'b1, ENTRY_GAP);
        fetch_one("t6a2", 32'h8, ADDI, 1'b1, ENTRY_GAP);
        fetch_one("t6a3", 32'hC, BEQ, 1'b1, ENTRY_GAP);
        branch_en   = 1'b1;
        branch_dest = 32'h0;
        tick();
        branch_en = 1'b0;
        fetch_one("t6b0", 32'h0, ADDI, PASS2_MEM, ENTRY_GAP);
        fetch_one("t6b1", 32'h4, ADDI2, PASS2_MEM, ENTRY_GAP);
        fetch_one("t6b2", 32'h8, ADDI, PASS2_MEM, ENTRY_GAP);
        fetch_one("t6b3", 32'hC, BEQ, PASS2_MEM, ENTRY_GAP);
        chk("t6_brwait_req", {31'b0, mem_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
